arf_recovery_sequencer: RTL
===========================

Name: arf_recovery_sequencer

Overview:
Owns the two read ports of the architectural register file. On a pipeline flush or exception it walks every architectural register, two per cycle, and streams (index, value) pairs to the rename/PRF restore logic over a valid/ready interface. Outside recovery it shares read port 0 with a single-beat debug reader. It sits between the commit stage, the ARF and the rename restore path.

Parameters:
XLEN, core_pkg::XLEN (32), register data width
ARCH_REGS, core_pkg::ARCH_REGS (32), number of architectural registers; must be even and a power of two
AW, $clog2(ARCH_REGS) (5), register index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
recover_req  in  1  start recovery (level or pulse); sampled only in IDLE
commit_busy  in  1  commit stage has ARF writes in flight; walk must not start while 1
recover_busy  out  1  high in every state except IDLE
recover_done  out  1  one-cycle pulse when the last pair has been accepted
arf_raddr0  out  AW  ARF read address, port 0
arf_rdata0  in  XLEN  ARF read data, port 0 (combinational, same cycle)
arf_raddr1  out  AW  ARF read address, port 1
arf_rdata1  in  XLEN  ARF read data, port 1
restore_valid  out  1  restore pair valid
restore_ready  in  1  restore consumer accepts the pair
restore_idx0  out  AW  even register index
restore_data0  out  XLEN  value of restore_idx0
restore_idx1  out  AW  odd register index (restore_idx0+1)
restore_data1  out  XLEN  value of restore_idx1
dbg_req  in  1  debug read request
dbg_addr  in  AW  debug register index
dbg_gnt  out  1  combinational grant, same cycle as dbg_req
dbg_rvalid  out  1  registered; high the cycle after a grant
dbg_rdata  out  XLEN  registered debug read data

Behaviour:
- Reset (asynchronous): state=IDLE, ptr=0. All registered outputs are 0: restore_valid, restore_idx*, restore_data*, recover_done, dbg_rvalid, dbg_rdata. An in-flight walk is abandoned, nothing further is emitted, and no recover_done is produced.
- FSM states: IDLE, DRAIN, WALK, FLUSH, DONE.
- IDLE: on recover_req go to DRAIN. recover_req has priority over dbg_req, so dbg_gnt=0 in that cycle.
- dbg_gnt = dbg_req & (state==IDLE) & !recover_req. While granted, arf_raddr0=dbg_addr. The next cycle has dbg_rvalid=1 and dbg_rdata=arf_rdata0 as sampled at grant (x0 reads 0 via the ARF). dbg_gnt=0 in all non-IDLE states, and dbg_rvalid is a one-cycle pulse.
- DRAIN: stay while commit_busy=1. Go to WALK the cycle after commit_busy=0 is sampled. If commit_busy=0 on DRAIN entry, DRAIN lasts exactly 1 cycle.
- WALK: arf_raddr0=ptr, arf_raddr1=ptr+1.
  - Capture when !restore_valid | restore_ready. On capture, register idx/data for both ports, set restore_valid=1 and add 2 to ptr.
  - Otherwise hold all outputs and ptr stable (no capture).
  - The capture of pair ptr=ARCH_REGS-2 moves to FLUSH and wraps ptr to 0.
- FLUSH: hold the last pair until restore_valid & restore_ready, then clear restore_valid and go to DONE.
- DONE: recover_done=1 for this cycle only, then go to IDLE.
- restore_valid stays high across back-to-back pairs whenever restore_ready=1. Pairs are emitted strictly in order 0/1, 2/3, … ARCH_REGS-2/ARCH_REGS-1.
- Unused read addresses: when not walking or granting debug, arf_raddr0=arf_raddr1=0.
- recover_req asserted in any non-IDLE state is ignored; ARF contents cannot change because commit is stalled.
- Latency with restore_ready=1 and commit_busy=0, ARCH_REGS=32:
  - cycle 0: IDLE sees req
  - cycle 1: DRAIN
  - cycles 2–17: WALK
  - cycles 3–18: restore_valid
  - cycle 18: FLUSH
  - cycle 19: recover_done
  - cycle 20: IDLE

Decomposition:
- core_pkg: XLEN and ARCH_REGS, plus a new typedef enum logic [2:0] rec_state_e {IDLE, DRAIN, WALK, FLUSH, DONE} for waveform and assertion reuse.
- One natural sub-module, restore_pair_buf: a single-entry valid/ready output register holding both idx/data pairs. It owns the capture condition and the restore_* outputs.
- The FSM, ptr and debug arbitration stay in the top.

Test Plan:
- Reset, then ARF preloaded with regs[i]=0x100+i (x0=0), restore_ready=1, pulse recover_req -> 16 consecutive pairs (0,0x0)/(1,0x101) … (30,0x11E)/(31,0x11F) on cycles 3–18; recover_done only on cycle 19; recover_busy cycles 1–19.
- commit_busy=1 for 5 cycles after recover_req -> stays in DRAIN, arf_raddr*=0, no restore_valid until 2 cycles after commit_busy falls.
- restore_ready toggling 1,0,0,1,… -> pair held stable while not ready, no duplicates or skips, all 16 pairs in order, recover_done after the final handshake.
- dbg_req with dbg_addr=7 in IDLE -> dbg_gnt same cycle, next cycle dbg_rvalid=1 with dbg_rdata=0x107. dbg_req with dbg_addr=0 -> dbg_rdata=0.
- dbg_req and recover_req in the same cycle -> dbg_gnt=0 and recovery starts. dbg_req held during the walk -> no grant until the cycle after recover_done.
- reset asserted mid-WALK after 5 pairs -> outputs 0 immediately, no recover_done. A new recover_req afterwards restarts from pair 0/1.

Source files
------------

// File: rtl/core_pkg.sv
// Core-wide architectural constants and the recovery sequencer state encoding.
package core_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ARCH_REGS = 32;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        WALK,
        FLUSH,
        DONE
    } rec_state_e;

endpackage

// File: rtl/restore_pair_buf.sv
// Single-entry valid/ready output register holding one even/odd (index, value) restore pair.
module restore_pair_buf #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            offer_i,
    input  logic [AW-1:0]   idx0_i,
    input  logic [XLEN-1:0] data0_i,
    input  logic [AW-1:0]   idx1_i,
    input  logic [XLEN-1:0] data1_i,
    output logic            capture_o,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [AW-1:0]   idx0_o,
    output logic [XLEN-1:0] data0_o,
    output logic [AW-1:0]   idx1_o,
    output logic [XLEN-1:0] data1_o
);

    logic            valid_q, valid_d;
    logic [AW-1:0]   idx0_q, idx1_q;
    logic [XLEN-1:0] data0_q, data1_q;

    assign capture_o = offer_i & (~valid_q | ready_i);

    always_comb begin
        valid_d = valid_q;
        if (capture_o) begin
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            idx0_q  <= '0;
            idx1_q  <= '0;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (capture_o) begin
                idx0_q  <= idx0_i;
                idx1_q  <= idx1_i;
                data0_q <= data0_i;
                data1_q <= data1_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign idx0_o  = idx0_q;
    assign idx1_o  = idx1_q;
    assign data0_o = data0_q;
    assign data1_o = data1_q;

endmodule

// File: rtl/arf_recovery_sequencer.sv
// Walks the architectural register file two registers per cycle on recovery and streams the
// pairs to the restore path; shares read port 0 with a single-beat debug reader when idle.
module arf_recovery_sequencer
    import core_pkg::*;
#(
    parameter int unsigned XLEN      = core_pkg::XLEN,
    parameter int unsigned ARCH_REGS = core_pkg::ARCH_REGS,
    parameter int unsigned AW        = $clog2(ARCH_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            recover_req,
    input  logic            commit_busy,
    output logic            recover_busy,
    output logic            recover_done,
    output logic [AW-1:0]   arf_raddr0,
    input  logic [XLEN-1:0] arf_rdata0,
    output logic [AW-1:0]   arf_raddr1,
    input  logic [XLEN-1:0] arf_rdata1,
    output logic            restore_valid,
    input  logic            restore_ready,
    output logic [AW-1:0]   restore_idx0,
    output logic [XLEN-1:0] restore_data0,
    output logic [AW-1:0]   restore_idx1,
    output logic [XLEN-1:0] restore_data1,
    input  logic            dbg_req,
    input  logic [AW-1:0]   dbg_addr,
    output logic            dbg_gnt,
    output logic            dbg_rvalid,
    output logic [XLEN-1:0] dbg_rdata
);

    localparam logic [AW-1:0] LastPair = AW'(ARCH_REGS - 2);

    rec_state_e      state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            walk;
    logic            capture;
    logic            dbg_rvalid_q;
    logic [XLEN-1:0] dbg_rdata_q;

    // Kept outside the FSM block so capture (which depends on it) forms no combinational loop.
    assign walk = (state_q == WALK);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        arf_raddr0 = '0;
        arf_raddr1 = '0;
        dbg_gnt    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (recover_req) begin
                    state_d = DRAIN;
                end else if (dbg_req) begin
                    dbg_gnt    = 1'b1;
                    arf_raddr0 = dbg_addr;
                end
            end
            DRAIN: begin
                if (!commit_busy) begin
                    state_d = WALK;
                end
            end
            WALK: begin
                arf_raddr0 = ptr_q;
                arf_raddr1 = ptr_q + AW'(1);
                if (capture) begin
                    // Wraps to 0 after the last pair, leaving ptr ready for the next walk.
                    ptr_d = ptr_q + AW'(2);
                    if (ptr_q == LastPair) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (restore_valid && restore_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            dbg_rvalid_q <= dbg_gnt;
            if (dbg_gnt) begin
                dbg_rdata_q <= arf_rdata0;
            end
        end
    end

    restore_pair_buf #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_pair_buf (
        .clk       (clk),
        .reset     (reset),
        .offer_i   (walk),
        .idx0_i    (arf_raddr0),
        .data0_i   (arf_rdata0),
        .idx1_i    (arf_raddr1),
        .data1_i   (arf_rdata1),
        .capture_o (capture),
        .ready_i   (restore_ready),
        .valid_o   (restore_valid),
        .idx0_o    (restore_idx0),
        .data0_o   (restore_data0),
        .idx1_o    (restore_idx1),
        .data1_o   (restore_data1)
    );

    assign recover_busy = (state_q != IDLE);
    assign recover_done = (state_q == DONE);
    assign dbg_rvalid   = dbg_rvalid_q;
    assign dbg_rdata    = dbg_rdata_q;

endmodule
